// File: rtl/mips_ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; owns the architectural HI/LO pair.
// One bit per cycle over DATA_WIDTH cycles, then a sign-fix cycle that commits HI/LO.
module mips_ex_muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_op1,
   input  logic [DATA_WIDTH-1:0] req_op2,
   input  logic                  req_mult,
   input  logic                  req_multu,
   input  logic                  req_div,
   input  logic                  req_divu,
   input  logic                  req_mthi,
   input  logic                  req_mtlo,
   input  logic                  flush,
   output logic                  busy,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state, state_next;

   logic                    accept;
   logic                    start_op;
   logic                    is_div_req;
   logic                    op1_neg;
   logic                    op2_neg;
   logic [DATA_WIDTH-1:0]   op1_mag;
   logic [DATA_WIDTH-1:0]   op2_mag;

   logic [CNT_WIDTH-1:0]    count;
   logic                    is_div_q;
   logic                    neg_res_q;
   logic                    neg_rem_q;
   logic                    div_zero_q;
   logic [DATA_WIDTH-1:0]   op1_raw_q;
   logic [DATA_WIDTH-1:0]   op2_mag_q;
   logic [2*DATA_WIDTH-1:0] prod_q;
   logic [DATA_WIDTH-1:0]   quot_q;
   logic [DATA_WIDTH-1:0]   rem_q;

   logic [DATA_WIDTH:0]     mul_sum;
   logic [2*DATA_WIDTH-1:0] prod_step;
   logic [DATA_WIDTH:0]     div_shift;
   logic [DATA_WIDTH:0]     div_diff;
   logic                    div_fits;
   logic [DATA_WIDTH-1:0]   rem_step;
   logic [DATA_WIDTH-1:0]   quot_step;

   logic [2*DATA_WIDTH-1:0] prod_fixed;
   logic [DATA_WIDTH-1:0]   quot_fixed;
   logic [DATA_WIDTH-1:0]   rem_fixed;
   logic [DATA_WIDTH-1:0]   fix_hi;
   logic [DATA_WIDTH-1:0]   fix_lo;

   assign req_ready  = (state == IDLE) && !flush;
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);
   assign accept     = req_valid && req_ready;
   assign is_div_req = req_div || req_divu;
   assign start_op   = accept && (req_mult || req_multu || is_div_req);

   // Signed ops run on magnitudes; the signs are re-applied in FIX
   assign op1_neg = (req_mult || req_div) && req_op1[DATA_WIDTH-1];
   assign op2_neg = (req_mult || req_div) && req_op2[DATA_WIDTH-1];
   assign op1_mag = op1_neg ? -req_op1 : req_op1;
   assign op2_mag = op2_neg ? -req_op2 : req_op2;

   assign mul_sum   = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (prod_q[0] ? {1'b0, op2_mag_q} : {(DATA_WIDTH+1){1'b0}});
   assign prod_step = {mul_sum, prod_q[DATA_WIDTH-1:1]};

   // Restoring divide: the remainder never exceeds the divisor, so W+1 bits cover the shift
   assign div_shift = {rem_q, quot_q[DATA_WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, op2_mag_q};
   assign div_fits  = !div_diff[DATA_WIDTH];
   assign rem_step  = div_fits ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
   assign quot_step = {quot_q[DATA_WIDTH-2:0], div_fits};

   assign prod_fixed = neg_res_q ? -prod_q : prod_q;
   assign quot_fixed = neg_res_q ? -quot_q : quot_q;
   assign rem_fixed  = neg_rem_q ? -rem_q  : rem_q;

   always_comb begin
      fix_hi = prod_fixed[2*DATA_WIDTH-1:DATA_WIDTH];
      fix_lo = prod_fixed[DATA_WIDTH-1:0];
      if (is_div_q) begin
         if (div_zero_q) begin
            fix_hi = op1_raw_q;
            fix_lo = {DATA_WIDTH{1'b1}};
         end else begin
            fix_hi = rem_fixed;
            fix_lo = quot_fixed;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_op) state_next = CALC;
         CALC: begin
            if (flush)                    state_next = IDLE;
            else if (count == LAST_COUNT) state_next = FIX;
         end
         FIX:  state_next = flush ? IDLE : DONE;
         DONE: if (flush || resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // HI/LO are written only by MTHI/MTLO in IDLE or by an unflushed FIX cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         hi         <= '0;
         lo         <= '0;
         count      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         op1_raw_q  <= '0;
         op2_mag_q  <= '0;
         prod_q     <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
      end else begin
         if (accept && req_mthi) hi <= req_op1;
         if (accept && req_mtlo) lo <= req_op1;
         if (start_op) begin
            count      <= '0;
            is_div_q   <= is_div_req;
            neg_res_q  <= op1_neg ^ op2_neg;
            neg_rem_q  <= op1_neg;
            div_zero_q <= (req_op2 == '0);
            op1_raw_q  <= req_op1;
            op2_mag_q  <= op2_mag;
            prod_q     <= {{DATA_WIDTH{1'b0}}, op1_mag};
            quot_q     <= op1_mag;
            rem_q      <= '0;
         end
         if (state == CALC) begin
            if (flush) begin
               count <= '0;
            end else begin
               count  <= count + 1'b1;
               prod_q <= prod_step;
               quot_q <= quot_step;
               rem_q  <= rem_step;
            end
         end
         if (state == FIX && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_mips_ex_muldiv_unit.sv
// Scoreboard bench for mips_ex_muldiv_unit: directed corner cases plus random ops checked
// against a plain-arithmetic reference model.
module tb_mips_ex_muldiv_unit;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   localparam int OP_NONE  = -1;
   localparam int OP_MULT  = 0;
   localparam int OP_MULTU = 1;
   localparam int OP_DIV   = 2;
   localparam int OP_DIVU  = 3;
   localparam int OP_MTHI  = 4;
   localparam int OP_MTLO  = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_op1 = '0;
   logic [W-1:0] req_op2 = '0;
   logic         req_mult = 1'b0, req_multu = 1'b0, req_div = 1'b0, req_divu = 1'b0;
   logic         req_mthi = 1'b0, req_mtlo = 1'b0;
   logic         flush = 1'b0;
   logic         busy;
   logic         resp_valid;
   logic         resp_ready = 1'b0;
   logic [W-1:0] hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           accept_edge;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           hold_mode = 1'b0;
   bit           seen = 1'b0;
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   mips_ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2),
      .req_mult(req_mult), .req_multu(req_multu), .req_div(req_div), .req_divu(req_divu),
      .req_mthi(req_mthi), .req_mtlo(req_mtlo),
      .flush(flush), .busy(busy),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Random completion back-pressure, held low while a test wants to park in DONE
   always @(posedge clk) begin
      #2;
      resp_ready = hold_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   always @(posedge clk) begin
      if (!rst && req_valid && req_ready)
         assert ($onehot({req_mult, req_multu, req_div, req_divu, req_mthi, req_mtlo}))
         else $error("[TB] FAIL onehot: opcode select not one-hot");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Architectural meaning of each op, straight from the ISA arithmetic
   function automatic logic [63:0] refModel(input int op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint          sa, sbv;
      longint unsigned ua, ub;
      logic [63:0]     q, r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      q   = '0;
      r   = '0;
      case (op)
         OP_MULT:  return 64'(sa * sbv);
         OP_MULTU: return 64'(ua * ub);
         OP_DIV: begin
            if (b == '0) return {a, 32'hFFFF_FFFF};
            q = 64'(sa / sbv);
            r = 64'(sa % sbv);
         end
         OP_DIVU: begin
            if (b == '0) return {a, 32'hFFFF_FFFF};
            q = ua / ub;
            r = ua % ub;
         end
         default: ;
      endcase
      return {r[31:0], q[31:0]};
   endfunction

   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
         end else begin
            if (!seen) begin
               seen = 1'b1;
               checkOutput("latency", 64'(cyc + 1 - sb[0].accept_edge), 64'(LAT));
            end
            checkOutput("resp_hi", 64'(hi), 64'(sb[0].hi));
            checkOutput("resp_lo", 64'(lo), 64'(sb[0].lo));
            if (resp_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic setOp(input int op);
      req_mult  = (op == OP_MULT);
      req_multu = (op == OP_MULTU);
      req_div   = (op == OP_DIV);
      req_divu  = (op == OP_DIVU);
      req_mthi  = (op == OP_MTHI);
      req_mtlo  = (op == OP_MTLO);
   endtask

   task automatic applyStimulus(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit track);
      int          n;
      logic [63:0] r;
      exp_t        e;
      @(negedge clk);
      req_op1   = a;
      req_op2   = b;
      setOp(op);
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
         req_valid = 1'b0;
         setOp(OP_NONE);
         return;
      end
      if (op <= OP_DIVU && track) begin
         r     = refModel(op, a, b);
         e.hi  = r[63:32];
         e.lo  = r[31:0];
         e.accept_edge = cyc + 1;
         sb.push_back(e);
         model_hi = e.hi;
         model_lo = e.lo;
      end else if (op == OP_MTHI) begin
         model_hi = a;
      end else if (op == OP_MTLO) begin
         model_lo = a;
      end
      @(negedge clk);
      req_valid = 1'b0;
      setOp(OP_NONE);
      if (op == OP_MTHI) checkOutput("mthi", 64'(hi), 64'(model_hi));
      if (op == OP_MTLO) checkOutput("mtlo", 64'(lo), 64'(model_lo));
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("[TB] FAIL idle_timeout: got busy=1 expected 0 within 300 cycles");
      end
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] old_lo;
      int           n;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_hi", 64'(hi), 64'h0);
      checkOutput("reset_lo", 64'(lo), 64'h0);
      checkOutput("reset_busy", 64'(busy), 64'h0);
      checkOutput("reset_resp_valid", 64'(resp_valid), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_req_ready", 64'(req_ready), 64'h1);

      applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
      waitIdle();
      checkOutput("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      checkOutput("mult_lo", 64'(lo), 64'hFFFF_FFEB);

      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      waitIdle();
      checkOutput("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      checkOutput("multu_lo", 64'(lo), 64'h0000_0001);

      // Park in DONE with resp_ready low; the monitor rechecks hi/lo every cycle
      hold_mode = 1'b1;
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_resp_valid", 64'(resp_valid), 64'h1);
      end
      hold_mode = 1'b0;
      waitIdle();
      checkOutput("div_hi", 64'(hi), 64'hFFFF_FFFF);
      checkOutput("div_lo", 64'(lo), 64'hFFFF_FFFD);

      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      waitIdle();
      checkOutput("div_ovf_hi", 64'(hi), 64'h0);
      checkOutput("div_ovf_lo", 64'(lo), 64'h8000_0000);

      applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b1);
      waitIdle();
      checkOutput("divu0_hi", 64'(hi), 64'h0000_0005);
      checkOutput("divu0_lo", 64'(lo), 64'hFFFF_FFFF);

      applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1);
      waitIdle();

      // Flush ten cycles into CALC: nothing commits, no response
      applyStimulus(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b1);
      applyStimulus(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkOutput("flush_busy", 64'(busy), 64'h0);
      checkOutput("flush_hi", 64'(hi), 64'hA5A5_A5A5);
      checkOutput("flush_resp_valid", 64'(resp_valid), 64'h0);
      checkOutput("flush_req_ready", 64'(req_ready), 64'h1);
      flush = 1'b1;
      #1;
      checkOutput("flush_idle_blocks", 64'(req_ready), 64'h0);
      @(negedge clk);
      flush = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("flush_no_resp", 64'(resp_valid), 64'h0);

      // MTLO presented while the unit is busy must wait
      old_lo = model_lo;
      applyStimulus(OP_MULTU, 32'h0000_1000, 32'h0000_0010, 1'b1);
      req_op1   = 32'h1234_5678;
      setOp(OP_MTLO);
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("busy_req_ready", 64'(req_ready), 64'h0);
         checkOutput("busy_lo", 64'(lo), 64'(old_lo));
         @(negedge clk);
      end
      req_valid = 1'b0;
      setOp(OP_NONE);
      waitIdle();

      // Reset in the middle of a divide discards it and clears HI/LO
      applyStimulus(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_hi = '0;
      model_lo = '0;
      checkOutput("midrst_hi", 64'(hi), 64'h0);
      checkOutput("midrst_lo", 64'(lo), 64'h0);
      checkOutput("midrst_busy", 64'(busy), 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 40; i++) begin
         applyStimulus($urandom_range(0, 5), pickOperand(), pickOperand(), 1'b1);
      end
      waitIdle();
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending responses expected 0", sb.size());
      end
      checkOutput("final_hi", 64'(hi), 64'(model_hi));
      checkOutput("final_lo", 64'(lo), 64'(model_lo));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
